// File: rtl/uart2wifi_core_pkg.sv
// Shared UART definitions for the uart2wifi core: frame geometry and the
// receiver state encoding, common to the RX stage, TX stage and baud divisor.
package uart2wifi_core_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart2wifi_core_uart_rx_if.sv
// Receiver-to-FIFO/register-block bundle: write strobe and byte toward the
// FIFO, full flag back from it, error pulses and busy toward the registers.
interface uart2wifi_core_uart_rx_if #(
  parameter int DATA_BITS = uart2wifi_core_pkg::UART_DATA_BITS
) ();

  logic                 wr;
  logic [DATA_BITS-1:0] write_data;
  logic                 fifo_full;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output wr, write_data, frame_err, overrun, busy,
    input  fifo_full
  );

  modport slave (
    input  wr, write_data, frame_err, overrun, busy,
    output fifo_full
  );

endinterface

// File: rtl/uart2wifi_core_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module uart2wifi_core_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first one is allowed to go metastable.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart2wifi_core_uart_rx.sv
// 8N1 UART receiver: oversamples rx on baudtick, deframes one character,
// and emits a one-cycle FIFO write or an error pulse at the stop bit.
module uart2wifi_core_uart_rx
  import uart2wifi_core_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baudtick,
  input  logic                     rx,
  uart2wifi_core_uart_rx_if.master rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t       state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 armed_q, armed_d;
  logic                 wr_q, wr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  uart2wifi_core_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Next-state, counters, shift register and pulse decisions.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which is what keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    armed_d = armed_q | rx_s;
    wr_d    = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      RX_IDLE: begin
        // Edge detection runs every clk, independent of baudtick.
        if (armed_q && !rx_s) begin
          state_d = RX_START;
          tick_d  = '0;
        end
      end

      RX_START: begin
        if (baudtick) begin
          if (tick_q == TICK_MID) begin
            if (!rx_s) begin
              state_d = RX_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = RX_IDLE;  // too short to be a start bit
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      RX_DATA: begin
        if (baudtick) begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) state_d = RX_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      RX_STOP: begin
        if (baudtick) begin
          if (tick_q == TICK_LAST) begin
            state_d = RX_IDLE;
            tick_d  = '0;
            if (rx_s) begin
              if (!rx_if.fifo_full) begin
                wr_d    = 1'b1;
                wdata_d = shift_q;
              end else begin
                ovr_d = 1'b1;
              end
            end else begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;  // a held break must go high before re-arming
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wdata_q <= '0;
      armed_q <= 1'b1;
      wr_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wdata_q <= wdata_d;
      armed_q <= armed_d;
      wr_q    <= wr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.wr         = wr_q;
  assign rx_if.write_data = wdata_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = ovr_q;
  assign rx_if.busy       = (state_q != RX_IDLE);

endmodule
